// File: rtl/alu_seq_pkg.sv
// Shared opcode, instruction-field and state definitions for the ALU op sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_ALUI0 = 4'b0000;
    localparam logic [3:0] OP_ALUI1 = 4'b0001;
    localparam logic [3:0] OP_ALUR0 = 4'b0010;
    localparam logic [3:0] OP_ALUR1 = 4'b0011;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int P1_MSB  = 11;
    localparam int P1_LSB  = 6;
    localparam int P2_MSB  = 5;
    localparam int P2_LSB  = 0;
    localparam int IDX_W   = 6;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD_A,
        SRC_B,
        LOAD_B,
        LATCH,
        WRITE,
        DONE,
        ERR
    } state_t;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ALUI0) || (op == OP_ALUI1);
    endfunction

    function automatic logic is_rr_op(input logic [3:0] op);
        return (op == OP_ALUR0) || (op == OP_ALUR1);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_rx_index_decode.sv
// Register index to one-hot enable decoder; index 0 maps to the MSB.
module rx_index_decode #(
    parameter int NUM_REGS = 5
) (
    input  logic [5:0]          i_index,
    output logic [NUM_REGS-1:0] o_onehot,
    output logic                o_valid
);

    always_comb begin
        o_onehot = '0;
        o_valid  = (int'(i_index) < NUM_REGS);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(i_index) == i) begin
                o_onehot[NUM_REGS-1-i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU instruction per start pulse over the shared datapath bus,
// driving register/ALU/immediate tri-state enables as Moore outputs.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 5,
    parameter int IMM_W    = 6,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         instruction,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                pc_inc,
    output logic [NUM_REGS-1:0] rx_out,
    output logic [NUM_REGS-1:0] rx_in,
    output logic                alu_in0,
    output logic                alu_in1,
    output logic                alu_out_latch,
    output logic                alu_out_en,
    output logic                imm_en,
    output logic [DATA_W-1:0]   imm_out
);

    state_t                r_state;
    state_t                w_next;
    logic [INSTR_W-1:0]    r_instr;

    logic [INSTR_W-1:0]    w_dec_src;
    logic [3:0]            w_opcode;
    logic [IDX_W-1:0]      w_p1;
    logic [IDX_W-1:0]      w_p2;
    logic [NUM_REGS-1:0]   w_p1_oh;
    logic [NUM_REGS-1:0]   w_p2_oh;
    logic                  w_p1_ok;
    logic                  w_p2_ok;
    logic                  w_rr;
    logic                  w_legal;
    logic [IMM_W-1:0]      w_imm_raw;
    logic [DATA_W-1:0]     w_imm_ext;

    // In IDLE the live instruction is decoded for the legality check; afterwards only the captured copy.
    assign w_dec_src = (r_state == IDLE) ? instruction : r_instr;
    assign w_opcode  = w_dec_src[OPC_MSB:OPC_LSB];
    assign w_p1      = w_dec_src[P1_MSB:P1_LSB];
    assign w_p2      = w_dec_src[P2_MSB:P2_LSB];
    assign w_rr      = is_rr_op(w_opcode);
    assign w_legal   = (is_imm_op(w_opcode) && w_p1_ok) ||
                       (is_rr_op(w_opcode) && w_p1_ok && w_p2_ok);

    rx_index_decode #(.NUM_REGS(NUM_REGS)) u_dec_p1 (
        .i_index  (w_p1),
        .o_onehot (w_p1_oh),
        .o_valid  (w_p1_ok)
    );

    rx_index_decode #(.NUM_REGS(NUM_REGS)) u_dec_p2 (
        .i_index  (w_p2),
        .o_onehot (w_p2_oh),
        .o_valid  (w_p2_ok)
    );

    assign w_imm_raw = w_p2[IMM_W-1:0];

    generate
        if (SIGN_EXT) begin : g_sext
            assign w_imm_ext = DATA_W'(signed'(w_imm_raw));
        end else begin : g_zext
            assign w_imm_ext = DATA_W'(w_imm_raw);
        end
    endgenerate

    assign imm_out = imm_en ? w_imm_ext : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && start) begin
                r_instr <= instruction;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        done          = 1'b0;
        illegal       = 1'b0;
        pc_inc        = 1'b0;
        rx_out        = '0;
        rx_in         = '0;
        alu_in0       = 1'b0;
        alu_in1       = 1'b0;
        alu_out_latch = 1'b0;
        alu_out_en    = 1'b0;
        imm_en        = 1'b0;
        busy          = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_legal ? FETCH : ERR;
                end
            end
            FETCH: begin
                pc_inc = 1'b1;
                rx_out = w_p1_oh;
                w_next = LOAD_A;
            end
            LOAD_A: begin
                rx_out  = w_p1_oh;
                alu_in0 = 1'b1;
                w_next  = SRC_B;
            end
            SRC_B: begin
                if (w_rr) rx_out = w_p2_oh;
                else      imm_en = 1'b1;
                w_next = LOAD_B;
            end
            LOAD_B: begin
                if (w_rr) rx_out = w_p2_oh;
                else      imm_en = 1'b1;
                alu_in1 = 1'b1;
                w_next  = LATCH;
            end
            LATCH: begin
                alu_out_latch = 1'b1;
                w_next        = WRITE;
            end
            WRITE: begin
                alu_out_en = 1'b1;
                rx_in      = w_p1_oh;
                w_next     = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
                pc_inc  = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: driver queues hand-computed per-instruction expectations,
// a negedge monitor accumulates the observed enable trace and checks it at done.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        c_start = 1'b0;
    logic [15:0] c_instruction = 16'h0000;

    always #5 clk = ~clk;

    logic        a_busy, a_done, a_illegal, a_pc_inc, a_alu_in0, a_alu_in1, a_alu_out_latch, a_alu_out_en, a_imm_en;
    logic [4:0]  a_rx_out, a_rx_in;
    logic [15:0] a_imm_out;
    logic        b_busy, b_done, b_illegal, b_pc_inc, b_alu_in0, b_alu_in1, b_alu_out_latch, b_alu_out_en, b_imm_en;
    logic [4:0]  b_rx_out, b_rx_in;
    logic [15:0] b_imm_out;
    logic        c_busy, c_done, c_illegal, c_pc_inc, c_alu_in0, c_alu_in1, c_alu_out_latch, c_alu_out_en, c_imm_en;
    logic [7:0]  c_rx_out, c_rx_in;
    logic [31:0] c_imm_out;

    alu_op_sequencer #(.DATA_W(16), .NUM_REGS(5), .IMM_W(6), .SIGN_EXT(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .busy(a_busy), .done(a_done), .illegal(a_illegal), .pc_inc(a_pc_inc),
        .rx_out(a_rx_out), .rx_in(a_rx_in), .alu_in0(a_alu_in0), .alu_in1(a_alu_in1),
        .alu_out_latch(a_alu_out_latch), .alu_out_en(a_alu_out_en),
        .imm_en(a_imm_en), .imm_out(a_imm_out)
    );

    alu_op_sequencer #(.DATA_W(16), .NUM_REGS(5), .IMM_W(6), .SIGN_EXT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .busy(b_busy), .done(b_done), .illegal(b_illegal), .pc_inc(b_pc_inc),
        .rx_out(b_rx_out), .rx_in(b_rx_in), .alu_in0(b_alu_in0), .alu_in1(b_alu_in1),
        .alu_out_latch(b_alu_out_latch), .alu_out_en(b_alu_out_en),
        .imm_en(b_imm_en), .imm_out(b_imm_out)
    );

    alu_op_sequencer #(.DATA_W(32), .NUM_REGS(8), .IMM_W(6), .SIGN_EXT(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .start(c_start), .instruction(c_instruction),
        .busy(c_busy), .done(c_done), .illegal(c_illegal), .pc_inc(c_pc_inc),
        .rx_out(c_rx_out), .rx_in(c_rx_in), .alu_in0(c_alu_in0), .alu_in1(c_alu_in1),
        .alu_out_latch(c_alu_out_latch), .alu_out_en(c_alu_out_en),
        .imm_en(c_imm_en), .imm_out(c_imm_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct {
        bit          ill;
        int          lat;
        int          gap;
        logic [4:0]  fetch_rx;
        logic [4:0]  a_src;
        logic [4:0]  b_src;
        logic [4:0]  dst;
        logic [15:0] imm_s;
        logic [15:0] imm_z;
        bit          imm_used;
    } exp_t;

    exp_t q[$];

    task automatic exp_push(input bit ill, input int lat, input int gap,
                            input logic [4:0] fetch_rx, input logic [4:0] a_src,
                            input logic [4:0] b_src, input logic [4:0] dst,
                            input logic [15:0] imm_s, input logic [15:0] imm_z, input bit imm_used);
        exp_t e;
        e.ill = ill; e.lat = lat; e.gap = gap; e.fetch_rx = fetch_rx; e.a_src = a_src;
        e.b_src = b_src; e.dst = dst; e.imm_s = imm_s; e.imm_z = imm_z; e.imm_used = imm_used;
        q.push_back(e);
    endtask

    // Monitor state
    int          gcyc = 0;
    int          last_done = -100;
    int          m_cyc = 0;
    int          m_pc = 0;
    logic [4:0]  m_fetch, m_a, m_b, m_dst;
    logic [15:0] m_is, m_iz;
    bit          m_iu;
    exp_t        m_e;

    task automatic mon_clear();
        m_cyc = 0; m_pc = 0; m_fetch = '0; m_a = '0; m_b = '0; m_dst = '0;
        m_is = '0; m_iz = '0; m_iu = 1'b0;
    endtask

    always @(negedge clk) begin
        gcyc++;
        chk("bus_excl_a", 64'($onehot0({|a_rx_out, a_imm_en, a_alu_out_en})), 64'(1));
        chk("bus_excl_b", 64'($onehot0({|b_rx_out, b_imm_en, b_alu_out_en})), 64'(1));
        chk("bus_excl_c", 64'($onehot0({|c_rx_out, c_imm_en, c_alu_out_en})), 64'(1));
        if (!a_imm_en) chk("imm_out_zero_a", 64'(a_imm_out), 64'(0));
        if (!c_imm_en) chk("imm_out_zero_c", 64'(c_imm_out), 64'(0));
        if (rst) begin
            mon_clear();
        end else if (a_busy) begin
            m_cyc++;
            if (a_pc_inc) begin m_pc++; m_fetch |= a_rx_out; end
            if (a_alu_in0) m_a |= a_rx_out;
            if (a_alu_in1) begin
                m_b |= a_rx_out;
                if (a_imm_en) m_is = a_imm_out;
                if (b_imm_en) m_iz = b_imm_out;
            end
            if (a_imm_en) m_iu = 1'b1;
            m_dst |= a_rx_in;
            if (a_done) begin
                chk("done_has_expectation", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    chk("illegal_flag", 64'(a_illegal), 64'(m_e.ill));
                    chk("latency", 64'(m_cyc), 64'(m_e.lat));
                    chk("pc_inc_count", 64'(m_pc), 64'(1));
                    chk("fetch_rx_out", 64'(m_fetch), 64'(m_e.fetch_rx));
                    chk("src_a", 64'(m_a), 64'(m_e.a_src));
                    chk("src_b_reg", 64'(m_b), 64'(m_e.b_src));
                    chk("src_b_imm_sext", 64'(m_is), 64'(m_e.imm_s));
                    chk("src_b_imm_zext", 64'(m_iz), 64'(m_e.imm_z));
                    chk("imm_en_used", 64'(m_iu), 64'(m_e.imm_used));
                    chk("dest_rx_in", 64'(m_dst), 64'(m_e.dst));
                    chk("done_cycle_enables",
                        64'({a_rx_out, a_rx_in, a_alu_in0, a_alu_in1, a_alu_out_latch, a_alu_out_en, a_imm_en}),
                        64'(0));
                    chk("b_done_aligned", 64'(b_done), 64'(1));
                    if (m_e.gap > 0) chk("done_gap", 64'(gcyc - last_done), 64'(m_e.gap));
                end
                last_done = gcyc;
                mon_clear();
            end
        end else begin
            chk("idle_outputs_zero",
                64'({a_done, a_illegal, a_pc_inc, a_rx_out, a_rx_in, a_alu_in0, a_alu_in1,
                     a_alu_out_latch, a_alu_out_en, a_imm_en, a_imm_out}), 64'(0));
            mon_clear();
        end
    end

    task automatic issue(input logic [15:0] ins);
        start = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        start = 1'b0;
        instruction = 16'hFFFF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (a_busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (a_busy) chk("idle_timeout", 64'(a_busy), 64'(0));
    endtask

    task automatic run_c(input logic [15:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] edst, input logic [31:0] eimm, input bit eimm_en);
        c_start = 1'b1;
        c_instruction = ins;
        @(posedge clk); #1;
        c_start = 1'b0;
        c_instruction = 16'h0000;
        for (int cy = 1; cy <= 7; cy++) begin
            @(negedge clk);
            case (cy)
                2: chk("c_load_a", 64'({c_alu_in0, c_rx_out}), 64'({1'b1, ea}));
                4: chk("c_load_b", 64'({c_alu_in1, c_imm_en, c_rx_out, c_imm_out}), 64'({1'b1, eimm_en, eb, eimm}));
                6: chk("c_write", 64'({c_alu_out_en, c_rx_in}), 64'({1'b1, edst}));
                7: chk("c_done", 64'({c_done, c_illegal, c_busy}), 64'(3'b101));
                default: ;
            endcase
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n_rxin;
        int n_done;
        mon_clear();
        // Reset held, then released
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_held_outputs",
            64'({a_busy, a_done, a_illegal, a_pc_inc, a_rx_out, a_rx_in, a_alu_in0, a_alu_in1,
                 a_alu_out_latch, a_alu_out_en, a_imm_en, a_imm_out}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_released_outputs",
            64'({a_busy, a_done, a_illegal, a_pc_inc, a_rx_out, a_rx_in, a_alu_in0, a_alu_in1,
                 a_alu_out_latch, a_alu_out_en, a_imm_en, a_imm_out}), 64'(0));
        @(posedge clk); #1;

        // Immediate, negative immediate: sign-extended on A, zero-extended on B
        exp_push(0, 7, 0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 16'hFFFF, 16'h003F, 1);
        issue(16'h00BF); wait_idle();
        // Reg-reg p1=0 p2=4
        exp_push(0, 7, 0, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 16'h0000, 16'h0000, 0);
        issue(16'h2004); wait_idle();
        // Illegal: p1 out of range, bad opcode, reg-reg p2 out of range
        exp_push(1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 0);
        issue(16'h0140); wait_idle();
        exp_push(1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 0);
        issue(16'h7041); wait_idle();
        exp_push(1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 0);
        issue(16'h3046); wait_idle();
        // Immediate mode with p2=9 stays legal
        exp_push(0, 7, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 16'h0009, 16'h0009, 1);
        issue(16'h1109); wait_idle();
        // Self-reference reg-reg p1=p2=3
        exp_push(0, 7, 0, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 16'h0000, 16'h0000, 0);
        issue(16'h30C3); wait_idle();
        // Immediate -32
        exp_push(0, 7, 0, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 16'hFFE0, 16'h0020, 1);
        issue(16'h1060); wait_idle();

        // Start and instruction changes while busy are ignored
        exp_push(0, 7, 0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 16'h0005, 16'h0005, 1);
        issue(16'h00C5);
        repeat (3) begin
            start = 1'b1;
            instruction = 16'h2004;
            @(posedge clk); #1;
        end
        start = 1'b0;
        instruction = 16'h7041;
        wait_idle();

        // Start held high: three back-to-back instructions, done every 8 cycles
        exp_push(0, 7, 0, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 16'h0000, 16'h0000, 0);
        exp_push(0, 7, 8, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 16'h0000, 16'h0000, 0);
        exp_push(0, 7, 8, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 16'h0000, 16'h0000, 0);
        start = 1'b1;
        instruction = 16'h2004;
        repeat (17) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset during LATCH aborts the instruction
        start = 1'b1;
        instruction = 16'h00BF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("in_latch_before_rst", 64'(a_alu_out_latch), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_outputs",
            64'({a_busy, a_done, a_illegal, a_pc_inc, a_rx_out, a_rx_in, a_alu_in0, a_alu_in1,
                 a_alu_out_latch, a_alu_out_en, a_imm_en, a_imm_out}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        n_rxin = 0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (|a_rx_in) n_rxin++;
            if (a_done) n_done++;
        end
        chk("no_rx_in_after_rst", 64'(n_rxin), 64'(0));
        chk("no_done_after_rst", 64'(n_done), 64'(0));
        @(posedge clk); #1;

        // NUM_REGS=8, DATA_W=32 regression
        run_c(16'h21C5, 8'h01, 8'h04, 8'h01, 32'h0000_0000, 1'b0);
        run_c(16'h017F, 8'h04, 8'h00, 8'h04, 32'hFFFF_FFFF, 1'b1);
        c_start = 1'b1;
        c_instruction = 16'h0200;
        @(posedge clk); #1;
        c_start = 1'b0;
        @(negedge clk);
        chk("c_err", 64'({c_done, c_illegal, c_pc_inc, c_busy, c_rx_out, c_rx_in}), 64'({4'b1111, 16'h0000}));
        @(negedge clk);
        chk("c_err_return_idle", 64'({c_busy, c_done}), 64'(0));
        @(posedge clk); #1;

        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
